// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and defaults for the unified memory arbiter
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arbState_t;

    localparam int STARVE_MAX_DEFAULT = 3;

endpackage

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating count of data grants issued while a fetch waits
module starve_counter #(
    parameter int STARVE_MAX = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       incEn,
    input  logic       clrEn,
    output logic [2:0] starveCnt
);

    localparam logic [2:0] CNT_LIMIT = 3'(STARVE_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= 3'd0;
        end else if (clrEn) begin
            starveCnt <= 3'd0;
        end else if (incEn && (starveCnt != CNT_LIMIT)) begin
            starveCnt <= starveCnt + 3'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction fetch and data access onto one memory port
module mem_arbiter
    import arm_mem_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy
);

    localparam logic [2:0] CNT_LIMIT = 3'(STARVE_MAX);

    arbState_t  state;
    logic [2:0] starveCnt;
    logic       starveFull;
    logic       grantD;
    logic       grantI;

    // Data wins ties until the fetch has been passed over STARVE_MAX times.
    assign starveFull = (starveCnt == CNT_LIMIT);
    assign grantD     = (state == IDLE) && d_req && (!if_req || !starveFull);
    assign grantI     = (state == IDLE) && if_req && !grantD;

    starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .incEn    (grantD && if_req),
        .clrEn    (grantI || !if_req),
        .starveCnt(starveCnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantD) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end else if (grantI) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= 32'd0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_rdy) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Completion is visible in the same cycle memory reports ready.
    assign if_ack   = (state == BUSY_I) && mem_rdy;
    assign d_ack    = (state == BUSY_D) && mem_rdy;
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign stall    = (if_req && !if_ack) || (d_req && !d_ack);

endmodule
